coremem_initiator: RTL

//   Memory-test initiator on the core data port (req/gnt/rvalid, one outstanding transaction).
//   On start, writes word_count words of pattern (seed+index) from base_addr_i, then optionally

---
 rtl/coremem_initiator_if.sv | 25 ++
 rtl/coremem_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coremem_initiator_if.sv
// Core data port bundle: req/gnt request phase, rvalid response phase.
// The initiator drives the request side; the responder drives gnt/rvalid/rdata.
interface coremem_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req_o;
  logic          data_gnt_i;
  logic          data_rvalid_i;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic [AW-1:0] data_addr_o;
  logic [DW-1:0] data_wdata_o;
  logic [DW-1:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/coremem_initiator.sv
// Memory-test initiator: writes word_count words of (seed+index) from base,
// then (with COREMEM_INITIATOR_READBACK_EN defined) reads them back and
// counts mismatches. One outstanding transaction on the data port.
// Without COREMEM_INITIATOR_READBACK_EN the read phase is absent and the
// error outputs are tied to zero.
module coremem_initiator #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] word_count_i,
  input  logic [DW-1:0] seed_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] err_count_o,
  output logic [AW-1:0] first_err_addr_o,
  coremem_initiator_if.master dbus
);

`ifdef COREMEM_INITIATOR_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] base_in;
  logic [CW-1:0] nidx;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_pat;

  assign base_in  = {base_addr_i[AW-1:2], 2'b00};
  assign nidx     = idx_q + CW'(1);
  assign nxt_addr = base_q + (AW'(nidx) << 2);
  assign nxt_pat  = seed_q + DW'(nidx);

`ifdef COREMEM_INITIATOR_READBACK_EN
  logic [CW-1:0] err_q, err_d;
  logic [AW-1:0] ferr_q, ferr_d;
  logic          ferr_seen_q, ferr_seen_d;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_pat;

  assign cur_addr = base_q + (AW'(idx_q) << 2);
  assign cur_pat  = seed_q + DW'(idx_q);
`else
  // Read data has no consumer when the verify phase is compiled out.
  logic unused_rdata;
  assign unused_rdata = ^dbus.data_rdata_i;
`endif

  // Next-state and next-output computation; outputs are all registered.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef COREMEM_INITIATOR_READBACK_EN
    err_d       = err_q;
    ferr_d      = ferr_q;
    ferr_seen_d = ferr_seen_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = base_in;
          count_d = word_count_i;
          seed_d  = seed_i;
          idx_d   = '0;
`ifdef COREMEM_INITIATOR_READBACK_EN
          err_d       = '0;
          ferr_d      = '0;
          ferr_seen_d = 1'b0;
`endif
          if (word_count_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = base_in;
            wdata_d = seed_i;
            busy_d  = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (dbus.data_gnt_i) begin
          state_d = WR_WAIT;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      WR_WAIT: begin
        if (dbus.data_rvalid_i) begin
          if (nidx == count_q) begin
            idx_d = '0;
`ifdef COREMEM_INITIATOR_READBACK_EN
            state_d = RD_REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = base_q;
            wdata_d = '0;
`else
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            idx_d   = nidx;
            state_d = WR_REQ;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = nxt_addr;
            wdata_d = nxt_pat;
          end
        end
      end
`ifdef COREMEM_INITIATOR_READBACK_EN
      RD_REQ: begin
        if (dbus.data_gnt_i) begin
          state_d = RD_WAIT;
          req_d   = 1'b0;
          addr_d  = '0;
        end
      end
      RD_WAIT: begin
        if (dbus.data_rvalid_i) begin
          if (dbus.data_rdata_i != cur_pat) begin
            if (err_q != '1) err_d = err_q + CW'(1);
            if (!ferr_seen_q) begin
              ferr_d      = cur_addr;
              ferr_seen_d = 1'b1;
            end
          end
          if (nidx == count_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = nidx;
            state_d = RD_REQ;
            req_d   = 1'b1;
            addr_d  = nxt_addr;
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COREMEM_INITIATOR_READBACK_EN
      err_q       <= '0;
      ferr_q      <= '0;
      ferr_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COREMEM_INITIATOR_READBACK_EN
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      ferr_seen_q <= ferr_seen_d;
`endif
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign dbus.data_req_o   = req_q;
  assign dbus.data_we_o    = we_q;
  assign dbus.data_be_o    = {4{req_q}};
  assign dbus.data_addr_o  = addr_q;
  assign dbus.data_wdata_o = wdata_q;
`ifdef COREMEM_INITIATOR_READBACK_EN
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_q;
`else
  assign err_count_o      = '0;
  assign first_err_addr_o = '0;
`endif

endmodule
